// File: rtl/aes_block_fifo_writer.sv
// Serialises one 128-bit AES result block into four 32-bit FIFO pushes, most significant word first.
// A block accepted at edge T is written at T+1..T+4; every cycle of full_fifo in SEND stalls the writer by one cycle.
module aes_block_fifo_writer #(
  parameter int BLOCK_WH        = 128,
  parameter int WORD_WH         = 32,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BLOCK_WH-1:0] block_data,
  input  logic                block_valid,
  output logic                block_ready,
  input  logic                full_fifo,
  output logic                write_fifo,
  output logic [WORD_WH-1:0]  data_in,
  output logic                busy,
  output logic                block_done
);

  localparam int CNT_WH = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [CNT_WH-1:0] LAST_WORD = CNT_WH'(WORDS_PER_BLOCK - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [CNT_WH-1:0]   word_cnt, word_cnt_nxt;
  logic [BLOCK_WH-1:0] shift_reg, shift_nxt;
  logic                done_nxt;

  // The FIFO always sees the top word of the shift register, so a stalled word stays put.
  assign data_in = shift_reg[BLOCK_WH-1 -: WORD_WH];

  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    shift_nxt    = shift_reg;
    done_nxt     = 1'b0;
    block_ready  = 1'b0;
    busy         = 1'b0;
    write_fifo   = 1'b0;
    case (state)
      IDLE: begin
        block_ready = 1'b1;
        if (block_valid) begin
          shift_nxt    = block_data;
          word_cnt_nxt = '0;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        busy = 1'b1;
        // Gate on full and reset combinationally so no push can land on a full FIFO or during reset.
        write_fifo = !full_fifo && !reset;
        if (write_fifo) begin
          shift_nxt = {shift_reg[BLOCK_WH-WORD_WH-1:0], {WORD_WH{1'b0}}};
          if (word_cnt == LAST_WORD) begin
            state_nxt    = IDLE;
            word_cnt_nxt = '0;
            done_nxt     = 1'b1;
          end else begin
            word_cnt_nxt = word_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word_cnt   <= '0;
      shift_reg  <= '0;
      block_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_cnt   <= word_cnt_nxt;
      shift_reg  <= shift_nxt;
      block_done <= done_nxt;
    end
  end

endmodule

// File: doc/aes_block_fifo_writer.md
Name: aes_block_fifo_writer

Overview:
Writer side of the 32-bit output FIFO. It accepts one 128-bit AES result block from the cipher datapath through a valid/ready handshake, splits it into four 32-bit words (most significant first) and pushes them into the output FIFO. Every push is gated on the FIFO's full flag, so no word is dropped and the FIFO never sees a write while it is full. It sits between the AES round engine and the output FIFO.

Parameters:
BLOCK_WH, 128, width of the AES result block.
WORD_WH, 32, FIFO word width; must equal the FIFO data_in width.
WORDS_PER_BLOCK, 4, equal to BLOCK_WH/WORD_WH; sets the word counter range 0..3.

Ports:
clk  input  1  system clock; every register samples on the rising edge.
reset  input  1  reset is synchronous and active-high.
block_data  input  BLOCK_WH  AES result block; bits [127:96] form word 0.
block_valid  input  1  the source presents a block on block_data.
block_ready  output  1  the writer can accept a block.
full_fifo  input  1  full flag from the output FIFO.
write_fifo  output  1  write strobe to the FIFO; one word per cycle while high.
data_in  output  WORD_WH  word presented to the FIFO.
busy  output  1  a block is being serialised.
block_done  output  1  one-cycle pulse after the last word of a block is written.

Behaviour:
- Reset is synchronous. The cycle after reset is sampled high: state=IDLE, word_cnt=0, shift register=0, block_done=0, block_ready=1, busy=0, data_in=0.
- While reset is high, write_fifo is forced to 0 combinationally, including during the reset cycle itself.
- There are two states, IDLE and SEND.
- IDLE:
  - block_ready=1, busy=0, write_fifo=0.
  - When block_valid=1 at a clock edge: load block_data into the shift register, set word_cnt=0, go to SEND.
- SEND:
  - block_ready=0, busy=1.
  - data_in = shift register bits [BLOCK_WH-1 : BLOCK_WH-WORD_WH]. This is combinational from the register, so data_in is stable while the writer is stalled.
  - write_fifo = !full_fifo. This is a combinational gate, so no write can land in the same cycle the FIFO reports full.
  - On each edge where write_fifo=1: shift the register left by WORD_WH (zero-fill) and increment word_cnt.
  - On an edge where write_fifo=1 and word_cnt=3: go to IDLE, set word_cnt=0 and set block_done=1 for exactly one cycle.
  - On an edge where write_fifo=0: state, word_cnt and the shift register hold.
- Handshake rules:
  - The transfer occurs on any edge with block_valid & block_ready.
  - block_valid is ignored while busy=1.
  - block_data is sampled only on the accept edge; the source may change it afterwards.
- Latency and throughput:
  - Block accepted at edge T, no backpressure: words are written at edges T+1..T+4.
  - block_done is high and block_ready returns high in the cycle after edge T+4.
  - Minimum spacing between accepted blocks is 5 cycles.
  - Each cycle of full_fifo=1 in SEND adds exactly one cycle.
- Boundary cases:
  - full_fifo=1 on the first SEND cycle: wait with data_in holding word 0.
  - full_fifo toggling every cycle: writes occur only on the cycles where it is low; word order is preserved.
  - A FIFO read in the same cycle as a write has no effect on the writer.
  - reset asserted mid-block: the partial block is discarded and the remaining words are never written. Words already pushed stay in the FIFO; flushing them is the system's job.
  - block_valid=1 in the same cycle as reset: the block is not accepted.
- word_cnt is 2 bits wide and never exceeds 3.

Test Plan:
1. Hold reset high for 2 cycles, including with block_valid=1 -> block_ready=1, write_fifo=0, busy=0, block_done=0, data_in=0, and no block is accepted.
2. full_fifo=0, accept block 0x00112233_44556677_8899AABB_CCDDEEFF at edge T -> write_fifo=1 at edges T+1..T+4 with data_in = 00112233, 44556677, 8899AABB, CCDDEEFF in that order. block_done=1 for one cycle and block_ready=1 after edge T+4.
3. Same block, with full_fifo=1 for 3 cycles once word 0 has been written -> write_fifo=0 and data_in=44556677 held for 3 cycles, then writing resumes. Exactly 4 writes in total, the last one at edge T+7.
4. block_valid held high with block A = all 0xA5 bytes, then block B = 0x0..0F counting bytes -> B is accepted only on the IDLE edge 5 cycles after A. Expect 8 writes in order: A words, then 00010203, 04050607, 08090A0B, 0C0D0E0F. block_valid during SEND captures nothing.
5. Assert reset for 1 cycle right after word 1 is written -> write_fifo=0 in the reset cycle, no further words from that block, block_ready=1 afterwards. A new block then starts from its word 0.
6. full_fifo=1 from the accept edge for 10 cycles -> no writes, busy=1, block_ready=0 and data_in = word 0 throughout. Normal 4-word completion follows once full_fifo drops.
